// File: rtl/vx_dxa_scheduler_pkg.sv
// DXA scheduler shared types: request, staging, launch, owner, response.
// Also holds the op codes and the round-robin pick helper.
package vx_dxa_scheduler_pkg;

  localparam int XLEN            = 32;
  localparam int CORE_ID_W       = 2;
  localparam int UUID_W          = 8;
  localparam int NW_W            = 2;
  localparam int DXA_DESC_SLOT_W = 4;
  localparam int BAR_ADDR_W      = 8;

  localparam logic [2:0] DXA_OP_SETUP0  = 3'd0;
  localparam logic [2:0] DXA_OP_SETUP1  = 3'd1;
  localparam logic [2:0] DXA_OP_COORD01 = 3'd2;
  localparam logic [2:0] DXA_OP_COORD23 = 3'd3;
  localparam logic [2:0] DXA_OP_ISSUE   = 3'd4;
  localparam logic [2:0] DXA_OP_LAUNCH  = 3'd5;

  typedef struct packed {
    logic [CORE_ID_W-1:0] core_id;
    logic [UUID_W-1:0]    uuid;
    logic [NW_W-1:0]      wid;
    logic [2:0]           op;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
  } dxa_req_t;

  localparam int DXA_REQ_DATAW = $bits(dxa_req_t);

  typedef struct packed {
    logic [XLEN-1:0]            smem_base;
    logic [DXA_DESC_SLOT_W-1:0] desc_slot;
    logic [BAR_ADDR_W-1:0]      bar_addr;
    logic [31:0]                coord0;
    logic [31:0]                coord1;
    logic [31:0]                coord2;
    logic [31:0]                coord3;
    logic                       armed;
  } dxa_stage_ctx_t;

  typedef struct packed {
    logic [CORE_ID_W-1:0]       core_id;
    logic [UUID_W-1:0]          uuid;
    logic [NW_W-1:0]            wid;
    logic [BAR_ADDR_W-1:0]      bar_addr;
    logic                       is_s2g;
    logic [DXA_DESC_SLOT_W-1:0] desc_slot;
    logic [XLEN-1:0]            smem_base;
    logic [31:0]                coord0;
    logic [31:0]                coord1;
    logic [31:0]                coord2;
    logic [31:0]                coord3;
  } dxa_launch_t;

  localparam int DXA_LAUNCH_DATAW = $bits(dxa_launch_t);

  typedef struct packed {
    logic [CORE_ID_W-1:0]  core_id;
    logic [UUID_W-1:0]     uuid;
    logic [NW_W-1:0]       wid;
    logic [BAR_ADDR_W-1:0] bar_addr;
  } dxa_owner_t;

  typedef struct packed {
    dxa_owner_t owner;
    logic [1:0] status;
  } dxa_rsp_t;

  localparam int DXA_RSP_DATAW = $bits(dxa_rsp_t);

  // Round-robin pick over up to 8 requesters, starting at ptr.
  localparam int ARB_MAX = 8;

  function automatic logic [2:0] rr_pick(
    input logic [ARB_MAX-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [2:0] win;
    logic       hit;
    int         idx;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < ARB_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !hit && req[idx]) begin
        win = 3'(idx);
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/vx_dxa_scheduler_ctx.sv
// Per-requester DXA staging register file with op decode.
// Ports: clk/reset, one write (en, idx, op, rs1, rs2), ctx array out.
module vx_dxa_scheduler_ctx
  import vx_dxa_scheduler_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int RQ_W     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [RQ_W-1:0]               wr_idx,
  input  logic [2:0]                    wr_op,
  input  logic [XLEN-1:0]               wr_rs1,
  input  logic [XLEN-1:0]               wr_rs2,
  output dxa_stage_ctx_t [NUM_REQS-1:0] ctx
);

  dxa_stage_ctx_t [NUM_REQS-1:0] ctx_q;

  assign ctx = ctx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_q <= '0;
    end else if (wr_en) begin
      unique case (wr_op)
        DXA_OP_SETUP0: begin
          ctx_q[wr_idx].smem_base <= wr_rs1;
          ctx_q[wr_idx].desc_slot <= wr_rs2[DXA_DESC_SLOT_W-1:0];
          ctx_q[wr_idx].armed     <= 1'b1;
        end
        DXA_OP_SETUP1: begin
          ctx_q[wr_idx].bar_addr <= wr_rs1[BAR_ADDR_W-1:0];
        end
        DXA_OP_COORD01: begin
          ctx_q[wr_idx].coord0 <= wr_rs1[31:0];
          ctx_q[wr_idx].coord1 <= wr_rs2[31:0];
        end
        DXA_OP_COORD23: begin
          ctx_q[wr_idx].coord2 <= wr_rs1[31:0];
          ctx_q[wr_idx].coord3 <= wr_rs2[31:0];
        end
        // an ISSUE that fires has launched (or was unarmed)
        DXA_OP_ISSUE: begin
          ctx_q[wr_idx].armed <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/vx_dxa_scheduler.sv
// DXA front-end: RR request arbitration, staging, engine launch, completions.
// Ports: req_* in, eng_launch_* / eng_done_* to engines, rsp_* out, busy, err.
module vx_dxa_scheduler
  import vx_dxa_scheduler_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int NUM_ENGINES = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQS-1:0]                    req_valid,
  input  logic [NUM_REQS-1:0][DXA_REQ_DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]                    req_ready,
  output logic [NUM_ENGINES-1:0]                 eng_launch_valid,
  output logic [DXA_LAUNCH_DATAW-1:0]            eng_launch_data,
  input  logic [NUM_ENGINES-1:0]                 eng_launch_ready,
  input  logic [NUM_ENGINES-1:0]                 eng_done_valid,
  input  logic [NUM_ENGINES-1:0][1:0]            eng_done_status,
  output logic [NUM_ENGINES-1:0]                 eng_done_ready,
  output logic                                   rsp_valid,
  output logic [DXA_RSP_DATAW-1:0]               rsp_data,
  input  logic                                   rsp_ready,
  output logic                                   busy,
  output logic                                   err_sticky
);

  localparam int RQ_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int EN_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic {S_IDLE, S_LAUNCH} state_t;

  state_t state, state_n;

  dxa_req_t [NUM_REQS-1:0]       reqs;
  dxa_stage_ctx_t [NUM_REQS-1:0] ctx;
  dxa_req_t       win_req;
  dxa_stage_ctx_t win_ctx;

  logic [NUM_REQS-1:0] elig;
  logic [RQ_W-1:0]     rq_ptr, rq_win, rq_nxt;
  logic                rq_fire, do_issue, bad_op;

  logic [NUM_ENGINES-1:0] eng_busy, dn_cand, alloc;
  logic [EN_W-1:0]        eng_sel, free_eng, dn_ptr, dn_win, dn_nxt;
  logic                   dn_fire, rsp_vld;

  dxa_owner_t [NUM_ENGINES-1:0] owner;
  dxa_owner_t  owner_n;
  dxa_launch_t launch_q, launch_n;
  dxa_rsp_t    rsp_q;

  assign reqs = req_data;

  vx_dxa_scheduler_ctx #(
    .NUM_REQS (NUM_REQS),
    .RQ_W     (RQ_W)
  ) u_ctx (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (rq_fire),
    .wr_idx (rq_win),
    .wr_op  (win_req.op),
    .wr_rs1 (win_req.rs1),
    .wr_rs2 (win_req.rs2),
    .ctx    (ctx)
  );

  // ISSUE waits for a free engine; blocked ones drop out of the race
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = req_valid[i] && (state == S_IDLE) &&
                ((reqs[i].op != DXA_OP_ISSUE) || (|(~eng_busy)));
    end
  end

  assign rq_win  = RQ_W'(rr_pick(8'(elig), 3'(rq_ptr), NUM_REQS));
  assign rq_fire = |elig;
  assign rq_nxt  = (rq_win == RQ_W'(NUM_REQS - 1)) ? '0 : rq_win + RQ_W'(1);
  assign win_req = reqs[rq_win];
  assign win_ctx = ctx[rq_win];

  assign req_ready = rq_fire ? (NUM_REQS'(1) << rq_win) : '0;

  assign do_issue = rq_fire && (win_req.op == DXA_OP_ISSUE) && win_ctx.armed;
  assign bad_op   = rq_fire && ((win_req.op >= DXA_OP_LAUNCH) ||
                    ((win_req.op == DXA_OP_ISSUE) && !win_ctx.armed));

  always_comb begin
    free_eng = '0;
    for (int e = NUM_ENGINES - 1; e >= 0; e--) begin
      if (!eng_busy[e]) free_eng = EN_W'(e);
    end
  end

  assign alloc = do_issue ? (NUM_ENGINES'(1) << free_eng) : '0;

  always_comb begin
    owner_n.core_id  = win_req.core_id;
    owner_n.uuid     = win_req.uuid;
    owner_n.wid      = win_req.wid;
    owner_n.bar_addr = win_ctx.bar_addr;
    launch_n.core_id   = win_req.core_id;
    launch_n.uuid      = win_req.uuid;
    launch_n.wid       = win_req.wid;
    launch_n.bar_addr  = win_ctx.bar_addr;
    launch_n.is_s2g    = win_req.rs1[0];
    launch_n.desc_slot = win_ctx.desc_slot;
    launch_n.smem_base = win_ctx.smem_base;
    launch_n.coord0    = win_ctx.coord0;
    launch_n.coord1    = win_ctx.coord1;
    launch_n.coord2    = win_ctx.coord2;
    launch_n.coord3    = win_ctx.coord3;
  end

  // completions only from engines we own; one-entry response buffer
  assign dn_cand = eng_done_valid & eng_busy;
  assign dn_win  = EN_W'(rr_pick(8'(dn_cand), 3'(dn_ptr), NUM_ENGINES));
  assign dn_fire = (|dn_cand) && (!rsp_vld || rsp_ready);
  assign dn_nxt  = (dn_win == EN_W'(NUM_ENGINES - 1)) ? '0 : dn_win + EN_W'(1);

  assign eng_done_ready = dn_fire ? (NUM_ENGINES'(1) << dn_win) : '0;

  always_comb begin
    state_n          = state;
    eng_launch_valid = '0;
    unique case (state)
      S_IDLE: begin
        if (do_issue) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        eng_launch_valid = NUM_ENGINES'(1) << eng_sel;
        if (eng_launch_ready[eng_sel]) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      eng_busy   <= '0;
      eng_sel    <= '0;
      launch_q   <= '0;
      owner      <= '0;
      rq_ptr     <= '0;
      dn_ptr     <= '0;
      rsp_vld    <= 1'b0;
      rsp_q      <= '0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_n;
      eng_busy <= (eng_busy & ~eng_done_ready) | alloc;
      if (rq_fire) rq_ptr <= rq_nxt;
      if (bad_op) err_sticky <= 1'b1;
      if (do_issue) begin
        eng_sel         <= free_eng;
        launch_q        <= launch_n;
        owner[free_eng] <= owner_n;
      end
      if (dn_fire) begin
        dn_ptr       <= dn_nxt;
        rsp_vld      <= 1'b1;
        rsp_q.owner  <= owner[dn_win];
        rsp_q.status <= eng_done_status[dn_win];
      end else if (rsp_ready) begin
        rsp_vld <= 1'b0;
      end
    end
  end

  assign eng_launch_data = launch_q;
  assign rsp_valid       = rsp_vld;
  assign rsp_data        = rsp_q;
  assign busy            = (|eng_busy) || (state == S_LAUNCH);

endmodule

// File: tb/tb_vx_dxa_scheduler.sv
// Directed scoreboard bench for vx_dxa_scheduler.
// Drives requests/engine handshakes, compares launches and responses.
module tb_vx_dxa_scheduler;
  import vx_dxa_scheduler_pkg::*;

  localparam int W = 256;
  typedef logic [W-1:0] wv_t;

  logic                         clk;
  logic                         reset;
  logic [3:0]                   req_valid;
  logic [3:0][DXA_REQ_DATAW-1:0] req_data;
  logic [3:0]                   req_ready;
  logic [1:0]                   eng_launch_valid;
  logic [DXA_LAUNCH_DATAW-1:0]  eng_launch_data;
  logic [1:0]                   eng_launch_ready;
  logic [1:0]                   eng_done_valid;
  logic [1:0][1:0]              eng_done_status;
  logic [1:0]                   eng_done_ready;
  logic                         rsp_valid;
  logic [DXA_RSP_DATAW-1:0]     rsp_data;
  logic                         rsp_ready;
  logic                         busy;
  logic                         err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  wv_t        exp_l[$];
  logic [1:0] exp_e[$];
  wv_t        exp_r[$];

  vx_dxa_scheduler #(
    .NUM_REQS    (4),
    .NUM_ENGINES (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .eng_launch_valid (eng_launch_valid),
    .eng_launch_data  (eng_launch_data),
    .eng_launch_ready (eng_launch_ready),
    .eng_done_valid   (eng_done_valid),
    .eng_done_status  (eng_done_status),
    .eng_done_ready   (eng_done_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_ready        (rsp_ready),
    .busy             (busy),
    .err_sticky       (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input wv_t obs, input wv_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DXA_REQ_DATAW-1:0] rq_word(
    input int r, input logic [2:0] op,
    input logic [31:0] rs1, input logic [31:0] rs2);
    dxa_req_t q;
    q.core_id = CORE_ID_W'(r);
    q.uuid    = UUID_W'(32'h20 + r);
    q.wid     = NW_W'(3 - r);
    q.op      = op;
    q.rs1     = rs1;
    q.rs2     = rs2;
    return q;
  endfunction

  function automatic wv_t mk_launch(
    input int r, input logic [7:0] bar, input logic s2g,
    input logic [3:0] slot, input logic [31:0] base,
    input logic [31:0] c0, input logic [31:0] c1,
    input logic [31:0] c2, input logic [31:0] c3);
    dxa_launch_t l;
    l.core_id   = CORE_ID_W'(r);
    l.uuid      = UUID_W'(32'h20 + r);
    l.wid       = NW_W'(3 - r);
    l.bar_addr  = bar;
    l.is_s2g    = s2g;
    l.desc_slot = slot;
    l.smem_base = base;
    l.coord0    = c0;
    l.coord1    = c1;
    l.coord2    = c2;
    l.coord3    = c3;
    return W'(l);
  endfunction

  function automatic wv_t mk_rsp(
    input int r, input logic [7:0] bar, input logic [1:0] st);
    dxa_rsp_t p;
    p.owner.core_id  = CORE_ID_W'(r);
    p.owner.uuid     = UUID_W'(32'h20 + r);
    p.owner.wid      = NW_W'(3 - r);
    p.owner.bar_addr = bar;
    p.status         = st;
    return W'(p);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, W'(req_ready), '0);
    chk({tag, "_launch_valid"}, W'(eng_launch_valid), '0);
    chk({tag, "_launch_data"}, W'(eng_launch_data), '0);
    chk({tag, "_done_ready"}, W'(eng_done_ready), '0);
    chk({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    chk({tag, "_rsp_data"}, W'(rsp_data), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_err"}, W'(err_sticky), '0);
  endtask

  task automatic send(input int r, input logic [2:0] op,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    req_data[r]  = rq_word(r, op, rs1, rs2);
    req_valid[r] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[r]) break;
    end
    chk($sformatf("accept_r%0d_op%0d", r, op), W'(req_ready[r]), W'(1));
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic run(input int n);
    logic [3:0] fired;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fired = req_ready & req_valid;
      if (|(eng_launch_valid & eng_launch_ready)) begin
        if (exp_l.size() == 0) begin
          chk("launch_extra", W'(eng_launch_valid), '0);
        end else begin
          chk("launch_eng", W'(eng_launch_valid), W'(exp_e.pop_front()));
          chk("launch_data", W'(eng_launch_data), exp_l.pop_front());
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_r.size() == 0) chk("rsp_extra", W'(rsp_valid), '0);
        else chk("rsp_data", W'(rsp_data), exp_r.pop_front());
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~fired;
    end
  endtask

  initial begin
    reset            = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    eng_launch_ready = '0;
    eng_done_valid   = '0;
    eng_done_status  = '0;
    rsp_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("rst");

    // staging + first launch on engine 0
    send(0, DXA_OP_SETUP0, 32'h100, 32'd3);
    send(0, DXA_OP_SETUP1, 32'd5, 32'd0);
    send(0, DXA_OP_COORD01, 32'd7, 32'd9);
    send(0, DXA_OP_COORD23, 32'd0, 32'd0);
    send(0, DXA_OP_ISSUE, 32'd1, 32'd0);
    chk("t1_launch_lat", W'(eng_launch_valid), W'(2'b01));
    chk("t1_launch_data", W'(eng_launch_data),
        mk_launch(0, 8'd5, 1'b1, 4'd3, 32'h100, 32'd7, 32'd9, 32'd0, 32'd0));
    req_data[1]  = rq_word(1, DXA_OP_SETUP1, 32'd1, 32'd0);
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("t1_no_ready_in_launch", W'(req_ready), '0);
    chk("t1_launch_hold", W'(eng_launch_valid), W'(2'b01));
    req_valid[1]     = 1'b0;
    eng_launch_ready = 2'b01;
    @(posedge clk);
    #1;
    chk("t1_launch_done", W'(eng_launch_valid), '0);
    chk("t1_busy", W'(busy), W'(1));
    eng_launch_ready = 2'b11;

    // completion of engine 0
    eng_done_valid     = 2'b01;
    eng_done_status[0] = 2'b01;
    @(negedge clk);
    chk("t2_done_ready", W'(eng_done_ready), W'(2'b01));
    @(posedge clk);
    #1;
    eng_done_valid = '0;
    chk("t2_rsp_valid", W'(rsp_valid), W'(1));
    chk("t2_rsp_data", W'(rsp_data), mk_rsp(0, 8'd5, 2'b01));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_rsp_drained", W'(rsp_valid), '0);
    chk("t2_busy_low", W'(busy), '0);

    // four armed ISSUEs, two engines
    for (int r = 0; r < 4; r++) begin
      send(r, DXA_OP_SETUP0, 32'h1000 * (r + 1), 32'(r + 4));
      send(r, DXA_OP_SETUP1, 32'(8'h10 + r), 32'd0);
    end
    exp_e.push_back(2'b01);
    exp_l.push_back(mk_launch(0, 8'h10, 1'b0, 4'd4, 32'h1000,
                              32'd7, 32'd9, 32'd0, 32'd0));
    exp_e.push_back(2'b10);
    exp_l.push_back(mk_launch(1, 8'h11, 1'b1, 4'd5, 32'h2000,
                              32'd0, 32'd0, 32'd0, 32'd0));
    for (int r = 0; r < 4; r++)
      req_data[r] = rq_word(r, DXA_OP_ISSUE, 32'(r & 1), 32'd0);
    req_valid = 4'b1111;
    run(8);
    chk("t3_two_launches", W'(exp_l.size()), '0);
    chk("t3_stalled", W'(req_ready), '0);
    chk("t3_busy", W'(busy), W'(1));

    eng_done_valid     = 2'b01;
    eng_done_status[0] = 2'b10;
    @(negedge clk);
    chk("t3_done0_ready", W'(eng_done_ready), W'(2'b01));
    chk("t3_no_same_cycle_reuse", W'(req_ready), '0);
    exp_r.push_back(mk_rsp(0, 8'h10, 2'b10));
    exp_e.push_back(2'b01);
    exp_l.push_back(mk_launch(2, 8'h12, 1'b0, 4'd6, 32'h3000,
                              32'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    eng_done_valid = '0;
    run(6);

    eng_done_valid     = 2'b10;
    eng_done_status[1] = 2'b11;
    @(negedge clk);
    chk("t3_done1_ready", W'(eng_done_ready), W'(2'b10));
    exp_r.push_back(mk_rsp(1, 8'h11, 2'b11));
    exp_e.push_back(2'b10);
    exp_l.push_back(mk_launch(3, 8'h13, 1'b1, 4'd7, 32'h4000,
                              32'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    eng_done_valid = '0;
    run(6);
    chk("t3_launch_q_empty", W'(exp_l.size()), '0);
    chk("t3_rsp_q_empty", W'(exp_r.size()), '0);

    // both engines done with response path stalled
    rsp_ready       = 1'b0;
    eng_done_status = {2'b00, 2'b01};
    eng_done_valid  = 2'b11;
    @(negedge clk);
    chk("t5_first_ack", W'(eng_done_ready), W'(2'b01));
    exp_r.push_back(mk_rsp(2, 8'h12, 2'b01));
    @(posedge clk);
    #1;
    eng_done_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_hold_%0d", c), W'(eng_done_ready), '0);
      chk($sformatf("t5_rsp_hold_%0d", c), W'(rsp_valid), W'(1));
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_second_ack", W'(eng_done_ready), W'(2'b10));
    chk("t5_rsp_first", W'(rsp_data), exp_r.pop_front());
    exp_r.push_back(mk_rsp(3, 8'h13, 2'b00));
    @(posedge clk);
    #1;
    eng_done_valid = '0;
    run(3);
    chk("t5_rsp_q_empty", W'(exp_r.size()), '0);
    chk("t5_rsp_idle", W'(rsp_valid), '0);
    chk("t5_busy_low", W'(busy), '0);
    rsp_ready = 1'b0;

    // unarmed ISSUE is dropped and flagged
    chk("t4_err_before", W'(err_sticky), '0);
    send(1, DXA_OP_ISSUE, 32'd0, 32'd0);
    chk("t4_no_launch", W'(eng_launch_valid), '0);
    chk("t4_err_set", W'(err_sticky), W'(1));
    chk("t4_busy", W'(busy), '0);

    // reset while a launch is pending
    eng_launch_ready = 2'b00;
    send(3, DXA_OP_SETUP0, 32'h5000, 32'd2);
    send(3, DXA_OP_ISSUE, 32'd1, 32'd0);
    chk("t6_pending", W'(eng_launch_valid), W'(2'b01));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("t6_rst");

    eng_launch_ready = 2'b11;
    send(0, DXA_OP_SETUP0, 32'h4000, 32'd7);
    send(0, DXA_OP_ISSUE, 32'd0, 32'd0);
    chk("t6_relaunch_eng", W'(eng_launch_valid), W'(2'b01));
    chk("t6_relaunch_data", W'(eng_launch_data),
        mk_launch(0, 8'd0, 1'b0, 4'd7, 32'h4000,
                  32'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;

    // done from an idle engine is ignored
    eng_done_valid = 2'b10;
    @(negedge clk);
    chk("t7_idle_done_ready", W'(eng_done_ready), '0);
    @(posedge clk);
    #1;
    eng_done_valid = '0;
    chk("t7_no_rsp", W'(rsp_valid), '0);
    chk("t7_err_clear", W'(err_sticky), '0);

    rsp_ready          = 1'b1;
    eng_done_status[0] = 2'b01;
    eng_done_valid     = 2'b01;
    exp_r.push_back(mk_rsp(0, 8'd0, 2'b01));
    @(negedge clk);
    chk("t7_done0_ready", W'(eng_done_ready), W'(2'b01));
    @(posedge clk);
    #1;
    eng_done_valid = '0;
    run(2);
    chk("t7_rsp_q_empty", W'(exp_r.size()), '0);
    chk("t7_busy_low", W'(busy), '0);

    // illegal LAUNCH op
    send(2, DXA_OP_LAUNCH, 32'd0, 32'd0);
    chk("t8_no_launch", W'(eng_launch_valid), '0);
    chk("t8_err_set", W'(err_sticky), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
